// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register slave: FSM state encoding,
// acknowledge levels and the R/W bit encoding.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_DEV_ADDR  = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_REG_ADDR  = 4'd3,
    ST_REG_ACK   = 4'd4,
    ST_WRITE     = 4'd5,
    ST_WRITE_ACK = 4'd6,
    ST_READ      = 4'd7,
    ST_READ_ACK  = 4'd8
  } state_t;

  localparam logic ACK      = 1'b0;
  localparam logic NACK     = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchroniser for SCL/SDA plus one history stage for edge,
// START and STOP detection. Everything resets to the idle-bus level (1).
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_d;
  logic       sda_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_ff <= 2'b11;
      sda_ff <= 2'b11;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[0], scl_in};
      sda_ff <= {sda_ff[0], sda_in};
      scl_d  <= scl_ff[1];
      sda_d  <= sda_ff[1];
    end
  end

  assign scl      = scl_ff[1];
  assign sda      = sda_ff[1];
  assign scl_rise = scl & ~scl_d;
  assign scl_fall = ~scl & scl_d;
  // SDA may only move while SCL is high (before and after) for START/STOP
  assign start    = scl & scl_d & sda_d & ~sda;
  assign stop     = scl & scl_d & ~sda_d & sda;

endmodule

// File: rtl/i2c_reg_slave.sv
// I2C slave exposing a small register file with auto-incrementing pointer.
//
// state        | meaning
// IDLE         | waiting for START, SDA released
// DEV_ADDR     | shifting in 7-bit device address + R/W
// ADDR_ACK     | driving ACK for the device address
// REG_ADDR     | shifting in register index
// REG_ACK      | driving ACK for the register index
// WRITE        | shifting in a data byte
// WRITE_ACK    | driving ACK for a data byte
// READ         | shifting out regs[pointer], MSB first
// READ_ACK     | sampling master ACK/NACK
module i2c_reg_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h33,
  parameter int         NUM_REGS = 3,
  parameter int         DATA_W   = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       scl_in,
  input  logic                       sda_in,
  output logic                       sda_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic                       wr_strobe,
  output logic [7:0]                 wr_addr,
  output logic                       busy
);

  state_t     state;
  logic [3:0] cnt;
  logic [7:0] sr;
  logic [7:0] ptr;
  logic       rw;
  logic       mack;

  logic scl, sda, scl_rise, scl_fall, start, stop;

  logic [7:0] rx_byte;
  logic [7:0] rd_byte;
  logic [7:0] ptr_next;

  i2c_bus_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .scl      (scl),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  assign rx_byte  = {sr[6:0], sda};
  assign ptr_next = (ptr == 8'(NUM_REGS - 1)) ? 8'd0 : ptr + 8'd1;

  always_comb begin
    rd_byte = '0;
    rd_byte[DATA_W-1:0] = regs[ptr*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      sr        <= 8'd0;
      ptr       <= 8'd0;
      rw        <= RW_WRITE;
      mack      <= NACK;
      sda_oe    <= 1'b0;
      regs      <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= 8'd0;
      busy      <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      if (!ena) begin
        state  <= ST_IDLE;
        cnt    <= 4'd0;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (start) begin
        // busy is kept across a repeated START until the address is judged
        state  <= ST_DEV_ADDR;
        cnt    <= 4'd0;
        sda_oe <= 1'b0;
      end else if (stop) begin
        state  <= ST_IDLE;
        cnt    <= 4'd0;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_DEV_ADDR: begin
            if (scl_rise && cnt != 4'd8) begin
              sr  <= rx_byte;
              cnt <= cnt + 4'd1;
            end else if (scl_fall && cnt == 4'd8) begin
              cnt <= 4'd0;
              if (sr[7:1] == DEV_ADDR) begin
                rw     <= sr[0];
                sda_oe <= 1'b1;
                busy   <= 1'b1;
                state  <= ST_ADDR_ACK;
              end else begin
                busy  <= 1'b0;
                state <= ST_IDLE;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              cnt <= 4'd0;
              if (rw == RW_READ) begin
                sr     <= rd_byte;
                sda_oe <= ~rd_byte[7];
                state  <= ST_READ;
              end else begin
                sda_oe <= 1'b0;
                state  <= ST_REG_ADDR;
              end
            end
          end
          ST_REG_ADDR: begin
            if (scl_rise && cnt != 4'd8) begin
              sr  <= rx_byte;
              cnt <= cnt + 4'd1;
            end else if (scl_fall && cnt == 4'd8) begin
              cnt <= 4'd0;
              if (9'(sr) < 9'(NUM_REGS)) begin
                ptr    <= sr;
                sda_oe <= 1'b1;
                state  <= ST_REG_ACK;
              end else begin
                busy  <= 1'b0;
                state <= ST_IDLE;
              end
            end
          end
          ST_REG_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              cnt    <= 4'd0;
              state  <= ST_WRITE;
            end
          end
          ST_WRITE: begin
            if (scl_rise && cnt != 4'd8) begin
              sr  <= rx_byte;
              cnt <= cnt + 4'd1;
              if (cnt == 4'd7) begin
                regs[ptr*DATA_W +: DATA_W] <= rx_byte[DATA_W-1:0];
                wr_strobe <= 1'b1;
                wr_addr   <= ptr;
                ptr       <= ptr_next;
              end
            end else if (scl_fall && cnt == 4'd8) begin
              cnt    <= 4'd0;
              sda_oe <= 1'b1;
              state  <= ST_WRITE_ACK;
            end
          end
          ST_WRITE_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              cnt    <= 4'd0;
              state  <= ST_WRITE;
            end
          end
          ST_READ: begin
            // bit 7 was put on the bus on entry; each fall presents the next bit
            if (scl_rise && cnt != 4'd8) begin
              cnt <= cnt + 4'd1;
            end else if (scl_fall && cnt == 4'd8) begin
              cnt    <= 4'd0;
              sda_oe <= 1'b0;
              ptr    <= ptr_next;
              state  <= ST_READ_ACK;
            end else if (scl_fall && cnt != 4'd0) begin
              sr     <= {sr[6:0], 1'b0};
              sda_oe <= ~sr[6];
            end
          end
          ST_READ_ACK: begin
            if (scl_rise) begin
              mack <= sda;
            end else if (scl_fall) begin
              cnt <= 4'd0;
              if (mack == ACK) begin
                sr     <= rd_byte;
                sda_oe <= ~rd_byte[7];
                state  <= ST_READ;
              end else begin
                sda_oe <= 1'b0;
                busy   <= 1'b0;
                state  <= ST_IDLE;
              end
            end
          end
          default: begin
            sda_oe <= 1'b0;
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/i2c_reg_slave.md
I2C_REG_SLAVE -- requirements
Module: i2c_reg_slave

Interface
REQ-001 Parameter DEV_ADDR, default 7'h33: 7-bit bus address the block answers to.
REQ-002 Parameter NUM_REGS, default 3: number of registers; legal range 1..256.
REQ-003 Parameter DATA_W, default 6: register width; legal range 1..8.
REQ-004 clk  in  1: single system clock; all logic is clocked on its rising edge.
REQ-005 rst_n  in  1: reset, synchronous, active-low.
REQ-006 ena  in  1: block enable; when low the block holds IDLE and does not drive SDA.
REQ-007 scl_in  in  1: asynchronous bus SCL.
REQ-008 sda_in  in  1: asynchronous bus SDA.
REQ-009 sda_oe  out  1: 1 drives SDA low (open-drain); 0 releases SDA.
REQ-010 regs  out  NUM_REGS*DATA_W: flat register file; register k occupies bits [k*DATA_W +: DATA_W].
REQ-011 wr_strobe  out  1: one-clk pulse on every register write.
REQ-012 wr_addr  out  8: index of the register written; valid while wr_strobe is high.
REQ-013 busy  out  1: high from an addressed START until STOP or return to IDLE.

Function
REQ-014 scl_in and sda_in SHALL each pass through a 2-FF synchroniser plus an edge-detect register; all bus events are taken from the synchronised signals.
REQ-015 START SHALL be detected as a synchronised SDA fall while SCL is high; STOP as an SDA rise while SCL is high.
REQ-016 START or STOP in any state SHALL abort the transfer, release sda_oe within 1 clk, and enter DEV_ADDR (START) or IDLE (STOP); this covers repeated START.
REQ-017 States: IDLE, DEV_ADDR, ADDR_ACK, REG_ADDR, REG_ACK, WRITE, WRITE_ACK, READ, READ_ACK.
REQ-018 SDA SHALL be sampled on the SCL rising edge, MSB first; sda_oe SHALL change only on the clk following an SCL falling edge.
REQ-019 DEV_ADDR SHALL shift 8 bits: a 7-bit address then the R/W bit (0 = write, 1 = read).
REQ-020 On address match the block SHALL go to ADDR_ACK; otherwise it SHALL go to IDLE without ACK.
REQ-021 ACK timing: sda_oe=1 from the SCL fall after bit 8 until the SCL fall after bit 9.
REQ-022 After ADDR_ACK: write goes to REG_ADDR; read goes to READ using the current pointer.
REQ-023 REG_ADDR SHALL shift 8 bits; if the value is < NUM_REGS it SHALL load the pointer and ACK; otherwise it SHALL NACK and go to IDLE.
REQ-024 After REG_ACK the block SHALL enter WRITE; each byte received SHALL be ACKed (WRITE_ACK).
REQ-025 Each write byte SHALL update regs[pointer] with the byte's low DATA_W bits 1 clk after the 8th SCL rise, and wr_strobe/wr_addr SHALL pulse in that same clk.
REQ-026 In READ the block SHALL shift out {zero pad, regs[pointer]} as 8 bits, MSB first; sda_oe = ~bit.
REQ-027 In READ_ACK, master ACK (SDA=0) SHALL load the next byte into READ; master NACK SHALL go to IDLE.
REQ-028 The pointer SHALL auto-increment after each data byte and wrap from NUM_REGS-1 to 0.
REQ-029 When ena is deasserted mid-transfer, the block SHALL enter IDLE within 1 clk; register contents SHALL be retained.

Reset
REQ-030 On rst_n=0 at a clk edge: state=IDLE, regs=0, pointer=0, sda_oe=0, wr_strobe=0, wr_addr=0, busy=0, bit counters=0, synchronisers=1 (bus idle).
REQ-031 Reset mid-transfer SHALL release SDA on that same clk edge; the first transfer after reset SHALL require a fresh START.

Structure
REQ-032 Package i2c_pkg SHALL hold the state enum, ACK/NACK constants and the R/W encoding.
REQ-033 Sub-module i2c_bus_sync (synchroniser plus rise/fall/START/STOP detection) SHALL be instantiated once for the SCL/SDA pair.

Verification
REQ-034 Write 0x33/W, reg 0x01, data 0x2A -> regs[1]=6'h2A, one wr_strobe with wr_addr=1, ACK on all 3 bytes.
REQ-035 Write reg 0x02, data 0x11, then 0x22 -> regs[2]=0x11, regs[0]=0x22 (wrap), two strobes.
REQ-036 Write sets pointer=1, repeated START, 0x33/R, master ACK then NACK -> returns regs[1] then regs[2], then IDLE.
REQ-037 Address 0x34 -> no ACK (sda_oe stays 0), no strobe; register address 0x05 -> NACK, regs unchanged.
REQ-038 STOP after 4 data bits, or rst_n low mid-byte -> sda_oe=0 within 1 clk, regs unchanged, next START works.
REQ-039 ena=0 during a full write -> no ACK, no strobe, busy=0.
